// File: rtl/seg_pkg.sv
// Shared page encoding, glyph constants and helpers for the 8-digit page scheduler.
package seg_pkg;

    typedef enum logic [1:0] {
        PG_SCORE = 2'd0,
        PG_BEST  = 2'd1,
        PG_TIME  = 2'd2,
        PG_FLASH = 2'd3
    } page_e;

    localparam logic [7:0] GL_S     = 8'h6D;
    localparam logic [7:0] GL_B     = 8'h7C;
    localparam logic [7:0] GL_T     = 8'h78;
    localparam logic [7:0] GL_BLANK = 8'h00;

    // Segment pattern {dp,g,f,e,d,c,b,a} for one BCD digit; dp is never lit.
    function automatic logic [7:0] glyph(input logic [3:0] bcd);
        logic [7:0] g;
        case (bcd)
            4'd0:    g = 8'h3F;
            4'd1:    g = 8'h06;
            4'd2:    g = 8'h5B;
            4'd3:    g = 8'h4F;
            4'd4:    g = 8'h66;
            4'd5:    g = 8'h6D;
            4'd6:    g = 8'h7D;
            4'd7:    g = 8'h07;
            4'd8:    g = 8'h7F;
            4'd9:    g = 8'h6F;
            default: g = GL_BLANK;
        endcase
        return g;
    endfunction

    // Counter width for a modulus; never below one bit so a modulus of 1 stays legal.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bin7_to_bcd3.sv
// Combinational 7-bit binary to three BCD digits using shift-and-add-3.
module bin7_to_bcd3 (
    input  logic [6:0] bin_i,
    output logic [3:0] hund_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    logic [11:0] bcd;

    always_comb begin
        bcd = '0;
        for (int i = 6; i >= 0; i--) begin
            if (bcd[3:0]  > 4'd4) bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4]  > 4'd4) bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] > 4'd4) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], bin_i[i]};
        end
    end

    assign hund_o = bcd[11:8];
    assign tens_o = bcd[7:4];
    assign ones_o = bcd[3:0];

endmodule

// File: rtl/seg_page_scheduler.sv
// Rotates score / best / time pages onto a multiplexed 8-digit display; a flash page
// overrides rotation after a new best score. All page state changes only at frame boundaries.
//
//  state    | meaning
//  PG_SCORE | current score, glyph S
//  PG_BEST  | best score, glyph b (only while game_over)
//  PG_TIME  | remaining seconds, glyph t
//  PG_FLASH | current score with glyph S, blinking, for FLASH_FRAMES frames
module seg_page_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 10000,
    parameter int unsigned DWELL_FRAMES = 250,
    parameter int unsigned FLASH_FRAMES = 500,
    parameter int unsigned BLINK_FRAMES = 60
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [6:0] score,
    input  logic [6:0] best_score,
    input  logic [6:0] time_left,
    input  logic       game_over,
    input  logic       flash_req,
    output logic [7:0] SEG_COM,
    output logic [7:0] SEG_DATA,
    output logic [1:0] page
);

    localparam int unsigned PW = cnt_w(SCAN_DIV);
    localparam int unsigned DW = cnt_w(DWELL_FRAMES);
    localparam int unsigned FW = cnt_w(FLASH_FRAMES);
    localparam int unsigned BW = cnt_w(BLINK_FRAMES);

    localparam logic [PW-1:0] PRE_TC   = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_TC = DW'(DWELL_FRAMES - 1);
    localparam logic [FW-1:0] FLASH_TC = FW'(FLASH_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_q, digit_d;
    page_e         page_q, page_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [FW-1:0] flash_q, flash_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          blink_ph_q, blink_ph_d;
    logic          pend_q, pend_d;
    logic [6:0]    snap_q, snap_d;
    logic [7:0]    seg_com_q, seg_com_d;
    logic [7:0]    seg_data_q, seg_data_d;

    logic          tick, frame_end, flash_now;
    logic [3:0]    hund, tens, ones;
    logic [7:0]    digit_glyph;

    bin7_to_bcd3 u_bcd (
        .bin_i  (snap_q),
        .hund_o (hund),
        .tens_o (tens),
        .ones_o (ones)
    );

    always_comb begin
        tick       = (presc_q == PRE_TC);
        frame_end  = tick && (digit_q == 3'd7);
        presc_d    = tick ? '0 : presc_q + PW'(1);
        digit_d    = tick ? digit_q + 3'd1 : digit_q;

        digit_glyph = GL_BLANK;
        case (digit_q)
            3'd7: digit_glyph = (page_q == PG_BEST) ? GL_B :
                                (page_q == PG_TIME) ? GL_T : GL_S;
            3'd2: if (hund != 4'd0) digit_glyph = glyph(hund);
            3'd1: if (hund != 4'd0 || tens != 4'd0) digit_glyph = glyph(tens);
            3'd0: digit_glyph = glyph(ones);
            default: digit_glyph = GL_BLANK;
        endcase
        if (page_q == PG_FLASH && blink_ph_q) digit_glyph = GL_BLANK;

        seg_com_d  = tick ? ~(8'd1 << digit_q) : seg_com_q;
        seg_data_d = tick ? digit_glyph : seg_data_q;
    end

    // Page FSM: evaluated only on the tick that ends digit 7, so a frame never tears.
    always_comb begin
        page_d     = page_q;
        dwell_d    = dwell_q;
        flash_d    = flash_q;
        blink_d    = blink_q;
        blink_ph_d = blink_ph_q;
        snap_d     = snap_q;
        flash_now  = pend_q | flash_req;
        pend_d     = flash_now;

        if (frame_end) begin
            pend_d = 1'b0;
            if (flash_now) begin
                page_d     = PG_FLASH;
                flash_d    = '0;
                blink_d    = '0;
                blink_ph_d = 1'b0;
            end else begin
                case (page_q)
                    PG_SCORE: if (dwell_q == DWELL_TC) page_d = game_over ? PG_BEST : PG_TIME;
                    PG_BEST: begin
                        if (!game_over)                page_d = PG_SCORE;
                        else if (dwell_q == DWELL_TC)  page_d = PG_TIME;
                    end
                    PG_TIME:  if (dwell_q == DWELL_TC) page_d = PG_SCORE;
                    PG_FLASH: begin
                        if (flash_q == FLASH_TC) begin
                            page_d = PG_SCORE;
                        end else begin
                            flash_d = flash_q + FW'(1);
                            if (blink_q == BLINK_TC) begin
                                blink_d    = '0;
                                blink_ph_d = ~blink_ph_q;
                            end else begin
                                blink_d = blink_q + BW'(1);
                            end
                        end
                    end
                    default: page_d = PG_SCORE;
                endcase
            end

            if (flash_now || page_d != page_q) dwell_d = '0;
            else if (page_q != PG_FLASH)       dwell_d = dwell_q + DW'(1);

            case (page_d)
                PG_BEST: snap_d = best_score;
                PG_TIME: snap_d = time_left;
                default: snap_d = score;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            presc_q    <= '0;
            digit_q    <= '0;
            page_q     <= PG_SCORE;
            dwell_q    <= '0;
            flash_q    <= '0;
            blink_q    <= '0;
            blink_ph_q <= 1'b0;
            pend_q     <= 1'b0;
            snap_q     <= '0;
            seg_com_q  <= 8'hFF;
            seg_data_q <= 8'h00;
        end else begin
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            page_q     <= page_d;
            dwell_q    <= dwell_d;
            flash_q    <= flash_d;
            blink_q    <= blink_d;
            blink_ph_q <= blink_ph_d;
            pend_q     <= pend_d;
            snap_q     <= snap_d;
            seg_com_q  <= seg_com_d;
            seg_data_q <= seg_data_d;
        end
    end

    assign SEG_COM  = seg_com_q;
    assign SEG_DATA = seg_data_q;
    assign page     = page_q;

endmodule

// File: tb/tb_seg_page_scheduler.sv
// Frame-level bench for seg_page_scheduler: a table of per-frame inputs and expected glyphs.
module tb_seg_page_scheduler;

    localparam int SD   = 4;
    localparam int NROW = 42;

    typedef struct packed {
        logic [6:0] score;
        logic [6:0] best;
        logic [6:0] tleft;
        logic       go;
        logic       flash;
        logic [1:0] pg;
        logic [7:0] d7;
        logic [7:0] d2;
        logic [7:0] d1;
        logic [7:0] d0;
    } row_t;

    logic       clk;
    logic       nRST;
    logic [6:0] score, best_score, time_left;
    logic       game_over, flash_req;
    logic [7:0] SEG_COM, SEG_DATA;
    logic [1:0] page;

    int   checks   = 0;
    int   failures = 0;
    row_t rows [NROW];
    row_t sb [$];

    seg_page_scheduler #(
        .SCAN_DIV     (4),
        .DWELL_FRAMES (3),
        .FLASH_FRAMES (4),
        .BLINK_FRAMES (1)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .score      (score),
        .best_score (best_score),
        .time_left  (time_left),
        .game_over  (game_over),
        .flash_req  (flash_req),
        .SEG_COM    (SEG_COM),
        .SEG_DATA   (SEG_DATA),
        .page       (page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(input int s, input int b, input int t, input bit go, input bit fl,
                                input int pg, input logic [7:0] d7, input logic [7:0] d2,
                                input logic [7:0] d1, input logic [7:0] d0);
        row_t r;
        r.score = 7'(s);
        r.best  = 7'(b);
        r.tleft = 7'(t);
        r.go    = go;
        r.flash = fl;
        r.pg    = 2'(pg);
        r.d7    = d7;
        r.d2    = d2;
        r.d1    = d1;
        r.d0    = d0;
        return r;
    endfunction

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h required %02h", nm, act, exp);
        end
    endtask

    task automatic apply_inputs(input row_t r);
        score      = r.score;
        best_score = r.best;
        time_left  = r.tleft;
        game_over  = r.go;
    endtask

    task automatic wait_slot0();
        int n;
        n = 0;
        while (SEG_COM !== 8'hFE && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (SEG_COM !== 8'hFE) begin
            checks++;
            failures++;
            $display("FAIL slot0_timeout: SEG_COM=%02h required FE", SEG_COM);
        end
    endtask

    // Captures one frame; the next row's inputs (and flash pulse) go in during digit 6,
    // i.e. mid-frame, so they become visible in the following frame only.
    task automatic do_frame(input row_t nxt, input bit push_nxt, input int idx);
        logic [7:0] d [8];
        logic [1:0] pg;
        bit         scan_ok;
        row_t       e;
        wait_slot0();
        pg      = page;
        scan_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (SEG_COM !== ~(8'd1 << k)) scan_ok = 1'b0;
            d[k] = SEG_DATA;
            if (k == 6 && push_nxt) begin
                apply_inputs(nxt);
                sb.push_back(nxt);
                if (nxt.flash) begin
                    flash_req = 1'b1;
                    @(posedge clk);
                    #1;
                    flash_req = 1'b0;
                    repeat (SD - 1) @(posedge clk);
                end else begin
                    repeat (SD) @(posedge clk);
                end
                #1;
            end else if (k < 7) begin
                repeat (SD) @(posedge clk);
                #1;
            end
        end
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL f%0d scoreboard: got empty queue required one entry", idx);
        end else begin
            e = sb.pop_front();
            chk8($sformatf("f%0d page", idx), {6'd0, pg}, {6'd0, e.pg});
            chk8($sformatf("f%0d d7", idx), d[7], e.d7);
            chk8($sformatf("f%0d d2", idx), d[2], e.d2);
            chk8($sformatf("f%0d d1", idx), d[1], e.d1);
            chk8($sformatf("f%0d d0", idx), d[0], e.d0);
            chk8($sformatf("f%0d d6..d3", idx), d[3] | d[4] | d[5] | d[6], 8'h00);
            chk8($sformatf("f%0d com_scan", idx), {7'd0, scan_ok}, 8'h01);
        end
    endtask

    initial begin
        int n;
        //                score best time go fl pg  d7     d2     d1     d0
        rows[0]  = mk( 50, 127,   9, 0, 0, 0, 8'h6D, 8'h00, 8'h00, 8'h3F);
        rows[1]  = mk( 50, 127,   9, 0, 0, 0, 8'h6D, 8'h00, 8'h6D, 8'h3F);
        rows[2]  = mk(100, 127,   9, 0, 0, 0, 8'h6D, 8'h06, 8'h3F, 8'h3F);
        rows[3]  = mk(100, 127,  45, 0, 0, 2, 8'h78, 8'h00, 8'h66, 8'h6D);
        rows[4]  = mk(100, 127, 120, 0, 0, 2, 8'h78, 8'h06, 8'h5B, 8'h3F);
        rows[5]  = mk(100, 127,   0, 0, 0, 2, 8'h78, 8'h00, 8'h00, 8'h3F);
        rows[6]  = mk(  7, 127,   0, 0, 0, 0, 8'h6D, 8'h00, 8'h00, 8'h07);
        rows[7]  = mk(127, 127,   0, 1, 0, 0, 8'h6D, 8'h06, 8'h5B, 8'h07);
        rows[8]  = mk( 99, 127,   0, 1, 0, 0, 8'h6D, 8'h00, 8'h6F, 8'h6F);
        rows[9]  = mk( 99, 127,   0, 1, 0, 1, 8'h7C, 8'h06, 8'h5B, 8'h07);
        rows[10] = mk( 99,  10,   0, 1, 0, 1, 8'h7C, 8'h00, 8'h06, 8'h3F);
        rows[11] = mk( 99,   0,   0, 1, 0, 1, 8'h7C, 8'h00, 8'h00, 8'h3F);
        rows[12] = mk( 99,   0,  60, 1, 0, 2, 8'h78, 8'h00, 8'h7D, 8'h3F);
        rows[13] = mk( 99,   0,  60, 1, 0, 2, 8'h78, 8'h00, 8'h7D, 8'h3F);
        rows[14] = mk( 99,   0,  60, 1, 0, 2, 8'h78, 8'h00, 8'h7D, 8'h3F);
        rows[15] = mk(  3,   0,  60, 1, 0, 0, 8'h6D, 8'h00, 8'h00, 8'h4F);
        rows[16] = mk(  3,   0,  60, 1, 0, 0, 8'h6D, 8'h00, 8'h00, 8'h4F);
        rows[17] = mk(  3,   0,  60, 1, 0, 0, 8'h6D, 8'h00, 8'h00, 8'h4F);
        rows[18] = mk(  3,  88,  60, 1, 0, 1, 8'h7C, 8'h00, 8'h7F, 8'h7F);
        rows[19] = mk( 42,  88,  60, 0, 0, 0, 8'h6D, 8'h00, 8'h66, 8'h5B);
        rows[20] = mk( 42,  88,  60, 0, 0, 0, 8'h6D, 8'h00, 8'h66, 8'h5B);
        rows[21] = mk( 42,  88,   5, 0, 0, 0, 8'h6D, 8'h00, 8'h66, 8'h5B);
        rows[22] = mk( 42,  88,   5, 0, 0, 2, 8'h78, 8'h00, 8'h00, 8'h6D);
        rows[23] = mk( 77,  88,   5, 0, 1, 3, 8'h6D, 8'h00, 8'h07, 8'h07);
        rows[24] = mk( 77,  88,   5, 0, 0, 3, 8'h00, 8'h00, 8'h00, 8'h00);
        rows[25] = mk( 12,  88,   5, 0, 0, 3, 8'h6D, 8'h00, 8'h06, 8'h5B);
        rows[26] = mk( 12,  88,   5, 0, 0, 3, 8'h00, 8'h00, 8'h00, 8'h00);
        rows[27] = mk( 12,  88,   5, 0, 0, 0, 8'h6D, 8'h00, 8'h06, 8'h5B);
        rows[28] = mk( 12,  88,   5, 0, 1, 3, 8'h6D, 8'h00, 8'h06, 8'h5B);
        rows[29] = mk( 12,  88,   5, 0, 0, 3, 8'h00, 8'h00, 8'h00, 8'h00);
        rows[30] = mk( 12,  88,   5, 0, 1, 3, 8'h6D, 8'h00, 8'h06, 8'h5B);
        rows[31] = mk( 12,  88,   5, 0, 0, 3, 8'h00, 8'h00, 8'h00, 8'h00);
        rows[32] = mk( 12,  88,   5, 0, 0, 3, 8'h6D, 8'h00, 8'h06, 8'h5B);
        rows[33] = mk( 12,  88,   5, 0, 0, 3, 8'h00, 8'h00, 8'h00, 8'h00);
        rows[34] = mk( 12,  88,   5, 0, 0, 0, 8'h6D, 8'h00, 8'h06, 8'h5B);
        rows[35] = mk( 12,  88,   5, 0, 0, 0, 8'h6D, 8'h00, 8'h06, 8'h5B);
        rows[36] = mk( 12,  88,   5, 0, 0, 0, 8'h6D, 8'h00, 8'h06, 8'h5B);
        rows[37] = mk( 64,  88,   5, 0, 1, 3, 8'h6D, 8'h00, 8'h7D, 8'h66);
        rows[38] = mk( 64,  88,   5, 0, 0, 3, 8'h00, 8'h00, 8'h00, 8'h00);
        rows[39] = mk( 64,  88,   5, 0, 0, 3, 8'h6D, 8'h00, 8'h7D, 8'h66);
        rows[40] = mk( 64,  88,   5, 0, 0, 3, 8'h00, 8'h00, 8'h00, 8'h00);
        rows[41] = mk( 64,  88,   5, 0, 0, 0, 8'h6D, 8'h00, 8'h7D, 8'h66);

        nRST      = 1'b1;
        flash_req = 1'b0;
        apply_inputs(rows[0]);
        #2 nRST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk8("reset SEG_COM", SEG_COM, 8'hFF);
        chk8("reset SEG_DATA", SEG_DATA, 8'h00);
        chk8("reset page", {6'd0, page}, 8'h00);

        nRST = 1'b1;
        sb.push_back(rows[0]);
        repeat (3) @(posedge clk);
        #1;
        chk8("pre-first-tick SEG_COM", SEG_COM, 8'hFF);
        @(posedge clk);
        #1;
        chk8("first-tick SEG_COM", SEG_COM, 8'hFE);

        for (int i = 0; i < NROW; i++) begin
            if (i + 1 < NROW) do_frame(rows[i + 1], 1'b1, i);
            else              do_frame(rows[i], 1'b0, i);
        end
        chk8("scoreboard drained", 8'(sb.size()), 8'h00);

        // Mid-frame score change: the rest of this frame keeps showing 64.
        wait_slot0();
        chk8("midframe d0", SEG_DATA, 8'h66);
        score = 7'd5;
        repeat (SD) @(posedge clk);
        #1;
        chk8("midframe d1", SEG_DATA, 8'h7D);
        repeat (SD) @(posedge clk);
        #1;
        chk8("midframe d2", SEG_DATA, 8'h00);
        wait_slot0();
        chk8("nextframe d0", SEG_DATA, 8'h6D);
        chk8("nextframe page", {6'd0, page}, 8'h00);

        // Flash on a boundary where SCORE dwell has expired, then reset while flashing.
        flash_req = 1'b1;
        @(posedge clk);
        #1;
        flash_req = 1'b0;
        n = 0;
        while (page !== 2'd3 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk8("flash entry page", {6'd0, page}, 8'h03);
        repeat (6) @(posedge clk);
        #1;
        chk8("flash lit d0", SEG_DATA, 8'h6D);
        chk8("flash lit com", SEG_COM, 8'hFE);
        #2 nRST = 1'b0;
        #1;
        chk8("async reset SEG_COM", SEG_COM, 8'hFF);
        chk8("async reset SEG_DATA", SEG_DATA, 8'h00);
        chk8("async reset page", {6'd0, page}, 8'h00);
        @(posedge clk);
        #1;
        nRST = 1'b1;
        repeat (SD) @(posedge clk);
        #1;
        chk8("post-reset SEG_COM", SEG_COM, 8'hFE);
        chk8("post-reset snapshot d0", SEG_DATA, 8'h3F);
        chk8("post-reset page", {6'd0, page}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
